// File: rtl/apb_bridge_pkg.sv
// Shared types and sizing helpers for the APB master bridge.
// The optional ACCESS-phase timeout is enabled with `define APB_BRIDGE_TIMEOUT_EN.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam int TIMEOUT_CYCLES_DEF = 256;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int timeout_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase watchdog for the APB master bridge; only built with APB_BRIDGE_TIMEOUT_EN.
// Counts stalled ACCESS cycles and flags the last one allowed before forced termination.
module apb_timeout_ctr
    import apb_bridge_pkg::*;
#(
    parameter int  LIMIT = TIMEOUT_CYCLES_DEF,
    localparam int W     = timeout_w(LIMIT)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    // The count holds k-1 during the k-th ACCESS cycle, so expiry lands on cycle LIMIT.
    assign expired = (count >= W'(LIMIT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response to single-transfer APB3/APB4 initiator, one transfer outstanding.
// Define APB_BRIDGE_TIMEOUT_EN to force-terminate ACCESS phases after TIMEOUT_CYCLES.
//
// state     | meaning
// ST_IDLE   | waiting for a request; req_ready high
// ST_SETUP  | psel=1, penable=0, one cycle
// ST_ACCESS | psel=1, penable=1 until pready (or timeout)
// ST_RESP   | rsp_valid held until rsp_ready
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int  ADDR_W         = 32,
    parameter int  DATA_W         = 32,
    parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int STRB_W         = strb_w(DATA_W)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [2:0]        req_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] out_paddr,
    output logic [2:0]        out_pprot,
    output logic              out_pwrite,
    output logic [DATA_W-1:0] out_pwdata,
    output logic [STRB_W-1:0] out_pstrb,
    output logic              out_psel,
    output logic              out_penable,
    input  logic              out_pready,
    input  logic              out_pslverr,
    input  logic [DATA_W-1:0] out_prdata
);

    state_t state, state_nxt;
    logic   timeout_hit;

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic ctr_expired;

    apb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == ST_SETUP),
        .enable  ((state == ST_ACCESS) && !out_pready),
        .expired (ctr_expired)
    );

    assign timeout_hit = (state == ST_ACCESS) && ctr_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        out_psel    = 1'b0;
        out_penable = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                out_psel  = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                out_psel    = 1'b1;
                out_penable = 1'b1;
                if (out_pready || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are frozen at accept so the APB side stays stable through pready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_paddr  <= '0;
            out_pprot  <= '0;
            out_pwrite <= 1'b0;
            out_pwdata <= '0;
            out_pstrb  <= '0;
        end else if (req_valid && req_ready) begin
            out_paddr  <= req_addr;
            out_pprot  <= req_prot;
            out_pwrite <= req_write;
            out_pwdata <= req_write ? req_wdata : '0;
            out_pstrb  <= req_write ? req_wstrb : '0;
        end
    end

    // A normal pready completion takes priority over a timeout in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (out_pready) begin
                rsp_rdata <= out_pwrite ? '0 : out_prdata;
                rsp_err   <= out_pslverr;
            end else if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; timeout scenario runs when
// APB_BRIDGE_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES=8).
module tb_apb_master_bridge;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] out_paddr;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_psel;
    logic        out_penable;
    logic        out_pready;
    logic        out_pslverr;
    logic [31:0] out_prdata;

    int errors = 0;
    int checks = 0;

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .out_paddr   (out_paddr),
        .out_pprot   (out_pprot),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pready  (out_pready),
        .out_pslverr (out_pslverr),
        .out_prdata  (out_prdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if ({out_psel, out_penable} !== 2'b00) begin errors++; $display("FAIL reset_psel_penable: got %b want 00", {out_psel, out_penable}); end
        checks++; if ({out_paddr, out_pwdata, out_pstrb, out_pwrite, out_pprot} !== '0) begin errors++; $display("FAIL reset_apb_fields: addr %h wdata %h strb %b want all 0", out_paddr, out_pwdata, out_pstrb); end
        checks++; if ({rsp_rdata, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp_fields: rdata %h err %b want 0", rsp_rdata, rsp_err); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_read_zero_wait();
        req_addr = 32'h4000_0004; req_write = 1'b0; req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF; req_prot = 3'b101;
        out_pready = 1'b1; out_prdata = 32'hCAFE_F00D; out_pslverr = 1'b0;
        req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_idle_ready: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0; req_addr = 32'h0;
        checks++; if ({out_psel, out_penable} !== 2'b10) begin errors++; $display("FAIL rd_setup_phase: got %b want 10", {out_psel, out_penable}); end
        checks++; if (out_paddr !== 32'h4000_0004 || out_pprot !== 3'b101 || out_pwrite !== 1'b0) begin errors++; $display("FAIL rd_setup_fields: addr %h prot %b wr %b want 40000004 101 0", out_paddr, out_pprot, out_pwrite); end
        checks++; if (out_pstrb !== 4'h0 || out_pwdata !== 32'h0) begin errors++; $display("FAIL rd_zero_strb_wdata: strb %b wdata %h want 0", out_pstrb, out_pwdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_busy_ready: got %b want 0", req_ready); end
        step();
        checks++; if ({out_psel, out_penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL rd_access_phase: got %b want 110", {out_psel, out_penable, rsp_valid}); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_response: valid %b rdata %h err %b want 1 cafef00d 0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if ({out_psel, out_penable} !== 2'b00) begin errors++; $display("FAIL rd_resp_psel: got %b want 00", {out_psel, out_penable}); end
        rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_consumed: valid %b ready %b want 0 1", rsp_valid, req_ready); end
        rsp_ready = 1'b0; out_pready = 1'b0;
    endtask

    task automatic test_write_wait_states();
        int hold;
        int unstable;
        hold = 0; unstable = 0;
        req_addr = 32'h8000_0010; req_write = 1'b1; req_wdata = 32'h1234_5678;
        req_wstrb = 4'b0110; req_prot = 3'b010;
        out_pready = 1'b0; out_prdata = 32'hDEAD_BEEF; out_pslverr = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_addr = 32'h5555_5555; req_wdata = 32'hAAAA_AAAA; req_wstrb = 4'hF;
        checks++; if ({out_psel, out_penable} !== 2'b10) begin errors++; $display("FAIL wr_setup_phase: got %b want 10", {out_psel, out_penable}); end
        step();
        for (int i = 0; i < 4; i++) begin
            if (out_psel === 1'b1 && out_penable === 1'b1) hold++;
            if (out_paddr !== 32'h8000_0010 || out_pwdata !== 32'h1234_5678 || out_pstrb !== 4'b0110
                || out_pwrite !== 1'b1 || out_pprot !== 3'b010) unstable++;
            if (i == 3) out_pready = 1'b1;
            step();
        end
        out_pready = 1'b0;
        checks++; if (hold !== 4) begin errors++; $display("FAIL wr_penable_hold: got %0d cycles want 4", hold); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL wr_fields_stable: got %0d unstable cycles want 0", unstable); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_response: valid %b rdata %h err %b want 1 00000000 0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (out_penable !== 1'b0) begin errors++; $display("FAIL wr_penable_drop: got %b want 0", out_penable); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_slverr_backpressure();
        int bad;
        bad = 0;
        req_addr = 32'h0000_0010; req_write = 1'b0; req_prot = 3'b000;
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = 32'h0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = 32'h0BAD_0BAD;
        step();
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0BAD_0BAD || req_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL err_hold: got %0d bad cycles want 0", bad); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_still_valid: valid %b err %b want 1 1", rsp_valid, rsp_err); end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL err_consumed: valid %b ready %b want 0 1", rsp_valid, req_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int rsp_cnt;
        int psel_cnt;
        int bad;
        rsp_cnt = 0; psel_cnt = 0; bad = 0;
        req_addr = 32'h0000_0100; req_write = 1'b0;
        out_pready = 1'b1; out_prdata = 32'h1111_2222; out_pslverr = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid && req_ready) acc.push_back(c);
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_rdata !== 32'h1111_2222) bad++;
            end
            if (out_psel === 1'b1) psel_cnt++;
            if (out_penable === 1'b1 && out_psel !== 1'b1) bad++;
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b0; out_pready = 1'b0;
        checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc.size()); end
        else begin
            checks++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", acc[1] - acc[0], acc[2] - acc[1]); end
        end
        checks++; if (rsp_cnt !== 3 || psel_cnt !== 6) begin errors++; $display("FAIL b2b_phases: rsp %0d psel %0d want 3 6", rsp_cnt, psel_cnt); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_data_or_penable: got %0d bad want 0", bad); end
    endtask

    task automatic test_reset_mid_access();
        req_addr = 32'h0000_0020; req_write = 1'b1; req_wdata = 32'h0000_00FF; req_wstrb = 4'h1;
        out_pready = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (out_penable !== 1'b1) begin errors++; $display("FAIL rst_pre_access: got %b want 1", out_penable); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({out_psel, out_penable, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_async_drop: got %b want 000", {out_psel, out_penable, rsp_valid}); end
        out_pready = 1'b1; out_prdata = 32'h0000_0077;
        step();
        step();
        reset_n = 1'b1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_release: ready %b valid %b rdata %h want 1 0 0", req_ready, rsp_valid, rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0 || out_psel !== 1'b0) begin errors++; $display("FAIL rst_no_ghost: valid %b psel %b want 0 0", rsp_valid, out_psel); end
        out_pready = 1'b0;
    endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int hold;
        hold = 0;
        req_addr = 32'h0000_0300; req_write = 1'b0;
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = 32'h9999_9999;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            if (out_penable === 1'b1) hold++;
            step();
        end
        checks++; if (hold !== 8) begin errors++; $display("FAIL to_access_cycles: got %0d want 8", hold); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || out_psel !== 1'b0) begin errors++; $display("FAIL to_forced: valid %b err %b rdata %h psel %b want 1 1 0 0", rsp_valid, rsp_err, rsp_rdata, out_psel); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        out_prdata = 32'h0000_0055;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) out_pready = 1'b1;
            step();
        end
        out_pready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_0055) begin errors++; $display("FAIL to_pready_wins: valid %b err %b rdata %h want 1 0 00000055", rsp_valid, rsp_err, rsp_rdata); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; req_prot = '0; rsp_ready = 1'b0;
        out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = '0;
        test_reset();
        test_read_zero_wait();
        test_write_wait_states();
        test_slverr_backpressure();
        test_back_to_back();
        test_reset_mid_access();
`ifdef APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
